// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locking arbiter sharing one UART transmitter
// between NREQ byte sources, pacing issues with a frame timer.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int BIT_CYCLES   = 434,
  parameter int FRAME_BITS   = 11,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_data_valid,
  output logic [7:0]        tx_data,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  localparam int FC_RAW = BIT_CYCLES * FRAME_BITS;
  localparam logic [15:0] FRAME_LOAD = 16'((FC_RAW > 65535 ? 65535 : FC_RAW) - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_TIMEOUT - 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;
  state_t            r_state;
  logic [PW-1:0]     r_ptr, r_owner;
  logic [15:0]       r_frame_cnt, r_hold_cnt;
  logic              r_lock, r_tx_valid, r_busy;
  logic [7:0]        r_tx_data;
  logic [NREQ-1:0]   r_grant;
  logic              w_found, w_take;
  logic [PW-1:0]     w_win, w_sel, w_idx, w_next_ptr;
  logic [NREQ-1:0]   w_win_oh, w_sel_oh;
  // Descending scan so the last hit is the one closest to r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win = w_idx;
      end
    end
  end
  assign w_win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
  assign w_sel      = (r_state == S_HOLD) ? r_owner : w_win;
  assign w_sel_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
  assign w_next_ptr = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
  assign req_ready  = !reset_n ? '0 :
                      (r_state == S_IDLE && w_found) ? w_win_oh :
                      (r_state == S_HOLD) ? (r_grant & req_valid) : '0;
  assign w_take        = |(req_valid & req_ready);
  assign tx_data_valid = r_tx_valid;
  assign tx_data       = r_tx_data;
  assign grant         = r_grant;
  assign busy          = r_busy;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_frame_cnt <= '0;
      r_hold_cnt  <= '0;
      r_lock      <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_data   <= 8'h00;
      r_grant     <= '0;
    end else begin
      r_tx_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_take) begin
            r_tx_data   <= req_data[{w_sel, 3'b000} +: 8];
            r_tx_valid  <= 1'b1;
            r_grant     <= w_sel_oh;
            r_owner     <= w_sel;
            r_lock      <= ~req_last[w_sel];
            r_busy      <= 1'b1;
            r_frame_cnt <= FRAME_LOAD;
            r_state     <= S_WAIT;
          end else if (r_state == S_HOLD) begin
            if (r_hold_cnt == '0) begin
              r_lock  <= 1'b0;
              r_ptr   <= w_next_ptr;
              r_grant <= '0;
              r_state <= S_IDLE;
            end else begin
              r_hold_cnt <= r_hold_cnt - 16'd1;
            end
          end
        end
        S_WAIT: begin
          if (r_frame_cnt == '0) begin
            r_busy <= 1'b0;
            if (r_lock) begin
              r_hold_cnt <= HOLD_LOAD;
              r_state    <= S_HOLD;
            end else begin
              r_ptr   <= w_next_ptr;
              r_grant <= '0;
              r_state <= S_IDLE;
            end
          end else begin
            r_frame_cnt <= r_frame_cnt - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random multi-source traffic against a time-based arbitration
// model; issued bytes are scoreboarded and checked whenever tx_data_valid pulses.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int FRAME = 44;
  localparam int HOLD = 8;
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready, grant;
  logic              tx_data_valid, busy;
  logic [7:0]        tx_data;
  int vectors = 0;
  int miscompares = 0;
  logic [8:0]        rq[NREQ][$];
  logic [NREQ+7:0]   sb[$];
  logic [NREQ+7:0]   sb_head;
  int                pause[NREQ];
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NREQ(NREQ), .BIT_CYCLES(4), .FRAME_BITS(11), .HOLD_TIMEOUT(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data_valid(tx_data_valid),
    .tx_data(tx_data), .grant(grant), .busy(busy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: every issue pulse must match the oldest expected byte and owner.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && tx_data_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
      else begin
        sb_head = sb.pop_front();
        check("tx_data", 32'(tx_data), 32'(sb_head[7:0]));
        check("grant_at_issue", 32'(grant), 32'(sb_head[NREQ+7:8]));
      end
    end
  end
  initial begin
    int e, t, owner, ptr, take_idx, n, ii;
    bit has_owner, lock, did_reset, exp_busy;
    logic [NREQ-1:0] er;
    for (int i = 0; i < NREQ; i++) pause[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 32'({tx_data_valid, tx_data, grant, busy, req_ready}), 32'd0);
    reset_n = 1'b1;
    has_owner = 0; lock = 0; did_reset = 0; owner = 0; ptr = 0;
    t = -1000; take_idx = -1; e = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      e++;
      if (take_idx >= 0) begin
        void'(rq[take_idx].pop_front());
        if ($urandom_range(0, 3) == 0) pause[take_idx] = e + int'($urandom_range(0, 15));
      end
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i].size() == 0 && $urandom_range(0, 7) == 0) begin
          n = int'($urandom_range(1, 3));
          for (int j = 0; j < n; j++) rq[i].push_back({(j == n - 1), 8'($urandom)});
        end
        req_valid[i] = rq[i].size() > 0 && e >= pause[i] && $urandom_range(0, 9) != 0;
        req_data[8*i +: 8] = rq[i].size() > 0 ? rq[i][0][7:0] : 8'($urandom);
        req_last[i] = rq[i].size() > 0 ? rq[i][0][8] : 1'($urandom);
      end
      // One asynchronous reset mid-frame with only requester 1 pending.
      if (!did_reset && c > 1500 && has_owner && e - t >= 5 && e - t <= 30) begin
        did_reset = 1;
        if (rq[1].size() == 0) rq[1].push_back({1'b1, 8'h5A});
        pause[1] = 0;
        req_valid = 4'b0010;
        req_data[15:8] = rq[1][0][7:0];
        req_last[1] = rq[1][0][8];
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({tx_data_valid, tx_data, grant, busy, req_ready}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        e += 2;
        reset_n = 1'b1;
        has_owner = 0; lock = 0; ptr = 0;
      end
      #1;
      exp_busy = has_owner && (e - 1 - t) >= 0 && (e - 1 - t) < FRAME;
      check("busy", 32'(busy), 32'(exp_busy));
      if (has_owner && ((!lock && e > t + FRAME) || (lock && e > t + FRAME + HOLD))) begin
        has_owner = 0;
        ptr = (owner + 1) % NREQ;
      end
      check("grant", 32'(grant), has_owner ? 32'(1) << owner : 32'd0);
      er = '0;
      if (!has_owner) begin
        for (int k = 0; k < NREQ; k++) begin
          ii = (ptr + k) % NREQ;
          if (er == '0 && req_valid[ii]) er[ii] = 1'b1;
        end
      end else if (e > t + FRAME) begin
        er[owner] = req_valid[owner];
      end
      check("req_ready", 32'(req_ready), 32'(er));
      take_idx = -1;
      for (int i = 0; i < NREQ; i++) if (er[i] && req_valid[i]) take_idx = i;
      if (take_idx >= 0) begin
        sb.push_back({NREQ'(1) << take_idx, req_data[8*take_idx +: 8]});
        t = e;
        has_owner = 1;
        owner = take_idx;
        lock = !req_last[take_idx];
      end
    end
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
